// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner that fetches over req/ack, offers words to decode over valid/ready,
// and keeps a FIFO of issued PCs so relative redirects from Execute resolve against exec_pc.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int HIST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        exec_adv,
  input  logic        global_disable,
  input  logic [31:0] delta_instruction,
  output logic [31:0] exec_pc,
  output logic        hist_full
);
  localparam int AW = $clog2(HIST_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc, target;
  logic [31:0] hist [HIST_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt, cnt_n;
  logic push, pop, bypass, full_n, load;
  assign imem_addr = pc;
  always_comb begin
    target = exec_pc + (delta_instruction << 2);
    load   = state == FETCH && imem_ack && !global_disable;
    push   = state == HOLD && instr_ready && !global_disable;
    pop    = exec_adv && !global_disable && cnt != '0;
    bypass = exec_adv && !global_disable && cnt == '0 && push;
    cnt_n  = global_disable ? '0 : cnt + CW'(push && !bypass) - CW'(pop);
    full_n = cnt_n == CW'(HIST_DEPTH);
    state_n = state;
    case (state)
      IDLE:    state_n = (run && (global_disable || !hist_full)) ? FETCH : IDLE;
      FETCH:   state_n = global_disable ? (imem_ack ? (run ? FETCH : IDLE) : DRAIN)
                                        : (imem_ack ? HOLD : FETCH);
      HOLD:    state_n = global_disable ? (run ? FETCH : IDLE)
                       : instr_ready ? ((run && !full_n) ? FETCH : IDLE) : HOLD;
      default: state_n = imem_ack ? ((run && (global_disable || !hist_full)) ? FETCH : IDLE) : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      exec_pc     <= '0;
      hist_full   <= 1'b0;
      cnt         <= '0;
      rd          <= '0;
      wr          <= '0;
    end else begin
      state       <= state_n;
      imem_req    <= state_n == FETCH || state_n == DRAIN;
      instr_valid <= state_n == HOLD;
      cnt         <= cnt_n;
      hist_full   <= full_n;
      pc          <= global_disable ? target : load ? pc + 32'd4 : pc;
      if (load) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (global_disable) begin
        rd <= '0;
        wr <= '0;
      end else begin
        if (push && !bypass) wr <= wr + 1'b1;
        if (pop) rd <= rd + 1'b1;
      end
      // an empty FIFO popped during a push forwards the pushed PC directly
      if (bypass) exec_pc <= instr_pc;
      else if (pop) exec_pc <= hist[rd];
    end
  end
  always_ff @(posedge clk)
    if (push && !bypass) hist[wr] <= instr_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a latency-programmable memory responder.
module tb_fetch_sequencer;
  localparam logic [31:0] MASK = 32'h5A5A_0000;
  logic clk = 0, rst_n = 0, run = 0, imem_req, imem_ack = 0, instr_valid, instr_ready = 0;
  logic exec_adv = 0, global_disable = 0, hist_full;
  logic [31:0] imem_addr, imem_rdata = 0, instr, instr_pc, delta_instruction = 0, exec_pc, cap = 0;
  int compared = 0, mismatched = 0, lat = 1, wait_cnt = 0, cyc = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .exec_adv(exec_adv),
    .global_disable(global_disable), .delta_instruction(delta_instruction),
    .exec_pc(exec_pc), .hist_full(hist_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory latches the address when a request starts, so a stale word keeps its old address
  always @(negedge clk) begin
    if (imem_ack) imem_ack = 0;
    else if (imem_req) begin
      if (wait_cnt == 0) cap = imem_addr;
      if (wait_cnt == lat) begin
        imem_ack = 1;
        imem_rdata = cap ^ MASK;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = instr_valid;
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = imem_req;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    compared++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_imem: req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr);
    end
    compared++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_instr: instr=%h pc=%h valid=%b expected 0/0/0", instr, instr_pc, instr_valid);
    end
    compared++;
    if (exec_pc !== 32'h0 || hist_full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hist: exec_pc=%h full=%b expected 0/0", exec_pc, hist_full);
    end
  endtask

  task automatic test_stream;
    bit ok;
    int t0 = 0;
    run = 1;
    instr_ready = 1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      compared++;
      if (!ok || imem_addr !== 32'(4 * i)) begin
        mismatched++;
        $display("FAIL stream_addr%0d: ok=%b addr=%h expected %h", i, ok, imem_addr, 32'(4 * i));
      end
      wait_valid(ok);
      compared++;
      if (!ok || instr_pc !== 32'(4 * i) || instr !== (32'(4 * i) ^ MASK)) begin
        mismatched++;
        $display("FAIL stream_instr%0d: ok=%b pc=%h instr=%h expected pc=%h", i, ok, instr_pc, instr, 32'(4 * i));
      end
      if (i > 0) begin
        compared++;
        if (cyc - t0 != 3) begin
          mismatched++;
          $display("FAIL stream_rate%0d: %0d cycles expected 3", i, cyc - t0);
        end
      end
      t0 = cyc;
    end
    @(negedge clk);
    instr_ready = 0;
    compared++;
    if (hist_full !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL full_stop: full=%b req=%b valid=%b expected 1/0/0", hist_full, imem_req, instr_valid);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL full_hold: req=%b expected 0", imem_req);
    end
    exec_adv = 1;
    @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'h0 || hist_full !== 1'b0) begin
      mismatched++;
      $display("FAIL pop_resume: exec_pc=%h full=%b expected 0/0", exec_pc, hist_full);
    end
    wait_req(ok);
    compared++;
    if (!ok || imem_addr !== 32'd16) begin
      mismatched++;
      $display("FAIL resume_addr: ok=%b addr=%h expected 10", ok, imem_addr);
    end
  endtask

  task automatic test_stall;
    bit ok;
    wait_valid(ok);
    compared++;
    if (!ok || instr_pc !== 32'd16 || instr !== (32'd16 ^ MASK)) begin
      mismatched++;
      $display("FAIL stall_first: ok=%b pc=%h instr=%h expected pc=10", ok, instr_pc, instr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'd16 || instr !== (32'd16 ^ MASK) || imem_req !== 1'b0 || hist_full !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h req=%b full=%b", i, instr_valid, instr_pc, instr, imem_req, hist_full);
      end
    end
    run = 0;
    instr_ready = 1;
    @(negedge clk);
    compared++;
    if (hist_full !== 1'b1 || instr_valid !== 1'b0 || exec_pc !== 32'h0) begin
      mismatched++;
      $display("FAIL stall_push: full=%b valid=%b exec_pc=%h expected 1/0/0", hist_full, instr_valid, exec_pc);
    end
  endtask

  task automatic test_redirect;
    bit ok;
    exec_adv = 1;
    repeat (2) @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'd8 || imem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_pre: exec_pc=%h req=%b expected 8/0", exec_pc, imem_req);
    end
    run = 1;
    global_disable = 1;
    delta_instruction = 32'hFFFF_FFFE;
    @(negedge clk);
    global_disable = 0;
    run = 0;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || hist_full !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_target: req=%b addr=%h valid=%b full=%b expected 1/0/0/0", imem_req, imem_addr, instr_valid, hist_full);
    end
    exec_adv = 1;
    @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'd8) begin
      mismatched++;
      $display("FAIL redir_empty_pop: exec_pc=%h expected 8", exec_pc);
    end
    wait_valid(ok);
    compared++;
    if (!ok || instr_pc !== 32'h0 || instr !== MASK) begin
      mismatched++;
      $display("FAIL redir_fetch: ok=%b pc=%h instr=%h expected pc=0 instr=%h", ok, instr_pc, instr, MASK);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    bit ok;
    exec_adv = 1;
    @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'h0) begin
      mismatched++;
      $display("FAIL simul_pop: exec_pc=%h expected 0", exec_pc);
    end
    instr_ready = 0;
    run = 1;
    wait_req(ok);
    run = 0;
    wait_valid(ok);
    compared++;
    if (!ok || instr_pc !== 32'd4) begin
      mismatched++;
      $display("FAIL simul_fetch: ok=%b pc=%h expected 4", ok, instr_pc);
    end
    instr_ready = 1;
    exec_adv = 1;
    @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'd4 || hist_full !== 1'b0 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL simul_bypass: exec_pc=%h full=%b valid=%b expected 4/0/0", exec_pc, hist_full, instr_valid);
    end
    exec_adv = 1;
    @(negedge clk);
    exec_adv = 0;
    compared++;
    if (exec_pc !== 32'd4) begin
      mismatched++;
      $display("FAIL simul_count: exec_pc=%h expected 4", exec_pc);
    end
  endtask

  task automatic test_drain;
    bit ok;
    lat = 3;
    run = 1;
    instr_ready = 1;
    wait_req(ok);
    compared++;
    if (!ok || imem_addr !== 32'd8) begin
      mismatched++;
      $display("FAIL drain_start: ok=%b addr=%h expected 8", ok, imem_addr);
    end
    global_disable = 1;
    delta_instruction = 32'd5;
    @(negedge clk);
    global_disable = 0;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd24 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_redirect: req=%b addr=%h valid=%b expected 1/18/0", imem_req, imem_addr, instr_valid);
    end
    wait_valid(ok);
    run = 0;
    compared++;
    if (!ok || instr_pc !== 32'd24 || instr !== (32'd24 ^ MASK)) begin
      mismatched++;
      $display("FAIL drain_target: ok=%b pc=%h instr=%h expected pc=18 instr=%h", ok, instr_pc, instr, 32'd24 ^ MASK);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_simultaneous;
    test_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
